// File: rtl/fwrisc_mem_arb_if.sv
// Bundle of the fetch port, load/store port and shared memory bus around fwrisc_mem_arb.
// Handshake: a requester holds valid and its payload stable until the matching ready,
// which completes the transaction in that cycle; valid drops in the cycle after ready.
interface fwrisc_mem_arb_if;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;

  logic [31:0] daddr;
  logic        dvalid;
  logic        dwrite;
  logic [31:0] dwdata;
  logic [3:0]  dstrb;
  logic        dready;
  logic [31:0] drdata;

  logic [31:0] maddr;
  logic        mvalid;
  logic        mwrite;
  logic [31:0] mwdata;
  logic [3:0]  mstrb;
  logic        mready;
  logic [31:0] mrdata;

  // Arbiter view.
  modport slave (
    input  iaddr, ivalid, daddr, dvalid, dwrite, dwdata, dstrb, mready, mrdata,
    output iready, idata, dready, drdata, maddr, mvalid, mwrite, mwdata, mstrb
  );

  // Environment view: requesters plus memory.
  modport master (
    output iaddr, ivalid, daddr, dvalid, dwrite, dwdata, dstrb, mready, mrdata,
    input  iready, idata, dready, drdata, maddr, mvalid, mwrite, mwdata, mstrb
  );
endinterface

// File: rtl/fwrisc_mem_arb.sv
// Shares one memory bus between the fwrisc fetch port and load/store port,
// one outstanding transaction at a time; ties go round-robin or to data.
module fwrisc_mem_arb #(
  parameter bit DATA_PRIORITY = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  fwrisc_mem_arb_if.slave    bus,
  output logic [1:0]         dbg_state,
  output logic               dbg_last_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e state;
  logic   last_grant;
  logic   grant_d;

  // Data wins when alone, when priority is fixed, or when fetch had the last turn.
  always_comb begin
    grant_d = bus.dvalid &&
              (!bus.ivalid || (DATA_PRIORITY == 1'b1) || (last_grant == GRANT_I));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      bus.mvalid <= 1'b0;
      bus.mwrite <= 1'b0;
      bus.maddr  <= 32'h0;
      bus.mwdata <= 32'h0;
      bus.mstrb  <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= BUSY_D;
            last_grant <= GRANT_D;
            bus.maddr  <= bus.daddr;
            bus.mwrite <= bus.dwrite;
            bus.mwdata <= bus.dwdata;
            bus.mstrb  <= bus.dstrb;
            bus.mvalid <= 1'b1;
          end else if (bus.ivalid) begin
            state      <= BUSY_I;
            last_grant <= GRANT_I;
            bus.maddr  <= bus.iaddr;
            bus.mwrite <= 1'b0;
            bus.mwdata <= 32'h0;
            bus.mstrb  <= 4'hF;
            bus.mvalid <= 1'b1;
          end
        end
        // Requests are not looked at here, so a requester still holding
        // valid in its completion cycle cannot be granted twice.
        BUSY_I, BUSY_D: begin
          if (bus.mready) begin
            bus.mvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iready = (state == BUSY_I) && bus.mready;
  assign bus.dready = (state == BUSY_D) && bus.mready;
  assign bus.idata  = bus.mrdata;
  assign bus.drdata = bus.mrdata;

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// Directed bench for fwrisc_mem_arb: round-robin and data-priority instances share
// one set of requester/memory drivers, selected by sel; a monitor scores grants and readies.
module tb_fwrisc_mem_arb;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus-side signals ----------------
  logic        sel;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic        ivalid, dvalid, dwrite, mready;
  logic [3:0]  dstrb;

  fwrisc_mem_arb_if ia ();
  fwrisc_mem_arb_if pa ();

  logic [1:0] ia_state, pa_state;
  logic       ia_last, pa_last;

  fwrisc_mem_arb #(.DATA_PRIORITY(1'b0)) u_rr (
    .clock(clock), .reset_n(reset_n), .bus(ia.slave),
    .dbg_state(ia_state), .dbg_last_grant(ia_last)
  );

  fwrisc_mem_arb #(.DATA_PRIORITY(1'b1)) u_prio (
    .clock(clock), .reset_n(reset_n), .bus(pa.slave),
    .dbg_state(pa_state), .dbg_last_grant(pa_last)
  );

  assign ia.iaddr  = iaddr;   assign pa.iaddr  = iaddr;
  assign ia.daddr  = daddr;   assign pa.daddr  = daddr;
  assign ia.dwrite = dwrite;  assign pa.dwrite = dwrite;
  assign ia.dwdata = dwdata;  assign pa.dwdata = dwdata;
  assign ia.dstrb  = dstrb;   assign pa.dstrb  = dstrb;
  assign ia.mrdata = mrdata;  assign pa.mrdata = mrdata;
  assign ia.ivalid = ivalid & ~sel;  assign pa.ivalid = ivalid & sel;
  assign ia.dvalid = dvalid & ~sel;  assign pa.dvalid = dvalid & sel;
  assign ia.mready = mready & ~sel;  assign pa.mready = mready & sel;

  // Selected instance outputs.
  logic        m_mvalid, m_mwrite, m_iready, m_dready, m_last;
  logic [31:0] m_maddr, m_mwdata, m_idata, m_drdata;
  logic [3:0]  m_mstrb;
  logic [1:0]  m_state;
  assign m_mvalid = sel ? pa.mvalid : ia.mvalid;
  assign m_mwrite = sel ? pa.mwrite : ia.mwrite;
  assign m_maddr  = sel ? pa.maddr  : ia.maddr;
  assign m_mwdata = sel ? pa.mwdata : ia.mwdata;
  assign m_mstrb  = sel ? pa.mstrb  : ia.mstrb;
  assign m_iready = sel ? pa.iready : ia.iready;
  assign m_dready = sel ? pa.dready : ia.dready;
  assign m_idata  = sel ? pa.idata  : ia.idata;
  assign m_drdata = sel ? pa.drdata : ia.drdata;
  assign m_state  = sel ? pa_state  : ia_state;
  assign m_last   = sel ? pa_last   : ia_last;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  // grant record: {is_data, mwrite, maddr, mwdata, mstrb}; response: {is_data, data}
  logic [69:0] exp_g_q[$];
  logic [32:0] exp_r_q[$];
  logic [31:0] ireq_q[$];
  logic [68:0] dreq_q[$];   // {write, addr, wdata, strb}

  int          rsp_delay = 0;
  logic [31:0] rsp_data  = 32'h0;
  logic        stray     = 1'b0;
  logic        drop_d    = 1'b0;

  task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [69:0] g_i(input logic [31:0] a);
    return {1'b0, 1'b0, a, 32'h0, 4'hF};
  endfunction

  function automatic logic [69:0] g_d(input logic w, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] s);
    return {1'b1, w, a, wd, s};
  endfunction

  // ---------------- driver: fetch requester ----------------
  initial begin : i_drv
    logic got;
    ivalid = 1'b0;
    iaddr  = 32'h0;
    forever begin
      @(negedge clock);
      got = m_iready;
      @(posedge clock);
      #1;
      if (got) ivalid = 1'b0;
      if (!ivalid && ireq_q.size() > 0) begin
        iaddr  = ireq_q.pop_front();
        ivalid = 1'b1;
      end
    end
  end

  // ---------------- driver: load/store requester ----------------
  initial begin : d_drv
    logic got;
    logic [68:0] r;
    dvalid = 1'b0;
    dwrite = 1'b0;
    daddr  = 32'h0;
    dwdata = 32'h0;
    dstrb  = 4'h0;
    forever begin
      @(negedge clock);
      got = m_dready;
      @(posedge clock);
      #1;
      if (got || drop_d) begin
        dvalid = 1'b0;
        drop_d = 1'b0;
      end
      if (!dvalid && dreq_q.size() > 0) begin
        r = dreq_q.pop_front();
        {dwrite, daddr, dwdata, dstrb} = r;
        dvalid = 1'b1;
      end
    end
  end

  // ---------------- driver: memory responder ----------------
  initial begin : mem_drv
    int wait_cnt;
    wait_cnt = 0;
    mready   = 1'b0;
    mrdata   = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      mready = 1'b0;
      if (stray) begin
        mready = 1'b1;
        mrdata = 32'hBAD0_0000;
      end else if (m_mvalid) begin
        if (wait_cnt >= rsp_delay) begin
          mready   = 1'b1;
          mrdata   = rsp_data;
          rsp_data = rsp_data + 32'h1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        mv_prev   = 1'b0;
  logic        cur_valid = 1'b0;
  logic [69:0] cur_g;

  always @(negedge clock) begin : monitor
    logic [69:0] got_g;
    logic [32:0] got_r;
    if (!reset_n) begin
      mv_prev   = 1'b0;
      cur_valid = 1'b0;
    end else begin
      got_g = {(m_state == 2'd2), m_mwrite, m_maddr, m_mwdata, m_mstrb};
      if (m_mvalid && !mv_prev) begin
        if (exp_g_q.size() == 0) begin
          total++;
          bad++;
          cur_valid = 1'b0;
          $display("FAIL unexpected_grant: got %h expected none at %0t", got_g, $time);
        end else begin
          cur_g     = exp_g_q.pop_front();
          cur_valid = 1'b1;
          check("grant", got_g, cur_g);
        end
      end else if (m_mvalid && cur_valid) begin
        check("bus_hold", got_g, cur_g);
      end
      mv_prev = m_mvalid;

      if (m_iready && m_dready) begin
        total++;
        bad++;
        $display("FAIL both_ready: got iready=1 dready=1 expected at most one at %0t", $time);
      end else if (m_iready || m_dready) begin
        got_r = {m_dready, (m_dready ? m_drdata : m_idata)};
        if (exp_r_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got %h expected none at %0t", got_r, $time);
        end else begin
          check("response", {37'h0, got_r}, {37'h0, exp_r_q.pop_front()});
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_g_q.size() != 0 || exp_r_q.size() != 0 || ireq_q.size() != 0 ||
            dreq_q.size() != 0 || ivalid || dvalid || m_mvalid) && n < budget) begin
      @(posedge clock);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending grants %0d pending responses expected 0",
               name, exp_g_q.size(), exp_r_q.size());
      exp_g_q.delete();
      exp_r_q.delete();
      ireq_q.delete();
      dreq_q.delete();
    end
    @(negedge clock);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int n;
    sel     = 1'b0;
    reset_n = 1'b0;

    // Reset held with both requests pending: nothing may be granted.
    ireq_q.push_back(32'h40);
    dreq_q.push_back({1'b0, 32'h3000, 32'h0, 4'hF});
    rsp_delay = 0;
    rsp_data  = 32'h1000;
    repeat (3) begin
      @(negedge clock);
      check("reset_outputs",
            {m_mvalid, m_mwrite, m_maddr, m_mwdata, m_mstrb, m_iready, m_dready}, 70'h0);
      check("reset_state", {m_state, m_last}, 70'h0);
    end
    // After release last_grant=I, so data takes the tie first.
    exp_g_q.push_back(g_d(1'b0, 32'h3000, 32'h0, 4'hF));
    exp_r_q.push_back({1'b1, 32'h1000});
    exp_g_q.push_back(g_i(32'h40));
    exp_r_q.push_back({1'b0, 32'h1001});
    #2 reset_n = 1'b1;
    drain("reset_release", 50);

    // Store with immediate completion.
    rsp_delay = 0;
    rsp_data  = 32'h55;
    exp_g_q.push_back(g_d(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011));
    exp_r_q.push_back({1'b1, 32'h55});
    dreq_q.push_back({1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011});
    drain("store", 50);

    // Single fetch with memory answering two cycles after mvalid.
    rsp_delay = 2;
    rsp_data  = 32'h13;
    exp_g_q.push_back(g_i(32'h100));
    exp_r_q.push_back({1'b0, 32'h13});
    ireq_q.push_back(32'h100);
    drain("fetch", 50);
    check("fetch_idle", {68'h0, m_state}, 70'h0);

    // Round-robin with both ports continuously requesting: D, I, D, I.
    rsp_delay = 0;
    rsp_data  = 32'hA0;
    exp_g_q.push_back(g_d(1'b0, 32'h4000, 32'h0, 4'hF));
    exp_r_q.push_back({1'b1, 32'hA0});
    exp_g_q.push_back(g_i(32'h200));
    exp_r_q.push_back({1'b0, 32'hA1});
    exp_g_q.push_back(g_d(1'b1, 32'h4004, 32'h12345678, 4'hC));
    exp_r_q.push_back({1'b1, 32'hA2});
    exp_g_q.push_back(g_i(32'h204));
    exp_r_q.push_back({1'b0, 32'hA3});
    dreq_q.push_back({1'b0, 32'h4000, 32'h0, 4'hF});
    dreq_q.push_back({1'b1, 32'h4004, 32'h12345678, 4'hC});
    ireq_q.push_back(32'h200);
    ireq_q.push_back(32'h204);
    drain("round_robin", 80);

    // mready while idle is ignored.
    stray = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stray_ready", {m_iready, m_dready, m_state, m_mvalid}, 70'h0);
    end
    stray = 1'b0;
    @(negedge clock);

    // Reset in the middle of a data transaction; memory never answers it.
    rsp_delay = 1000;
    exp_g_q.push_back(g_d(1'b0, 32'h5000, 32'h0, 4'hF));
    dreq_q.push_back({1'b0, 32'h5000, 32'h0, 4'hF});
    n = 0;
    while (m_state != 2'd2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("busy_d_reached", {68'h0, m_state}, 70'h2);
    ireq_q.push_back(32'h300);
    exp_g_q.push_back(g_i(32'h300));
    exp_r_q.push_back({1'b0, 32'h77});
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_clear", {m_mvalid, m_maddr, m_mstrb, m_state, m_last}, 70'h0);
    drop_d = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rsp_delay = 0;
    rsp_data  = 32'h77;
    #2 reset_n = 1'b1;
    drain("mid_reset", 50);

    // Fixed data priority: data wins every tie while it keeps requesting.
    sel      = 1'b1;
    @(negedge clock);
    rsp_delay = 0;
    rsp_data  = 32'hB0;
    exp_g_q.push_back(g_d(1'b0, 32'h6000, 32'h0, 4'hF));
    exp_r_q.push_back({1'b1, 32'hB0});
    exp_g_q.push_back(g_d(1'b0, 32'h6004, 32'h0, 4'hF));
    exp_r_q.push_back({1'b1, 32'hB1});
    exp_g_q.push_back(g_d(1'b0, 32'h6008, 32'h0, 4'hF));
    exp_r_q.push_back({1'b1, 32'hB2});
    exp_g_q.push_back(g_i(32'h700));
    exp_r_q.push_back({1'b0, 32'hB3});
    dreq_q.push_back({1'b0, 32'h6000, 32'h0, 4'hF});
    dreq_q.push_back({1'b0, 32'h6004, 32'h0, 4'hF});
    dreq_q.push_back({1'b0, 32'h6008, 32'h0, 4'hF});
    ireq_q.push_back(32'h700);
    drain("data_priority", 80);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
